// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scan controller for an N-digit 7-segment display.
// Latches a hex value, scans the digits with a dead time, blanks leading zeros and updates only at frame boundaries.
module seven_seg_scanner #(
   parameter int N_DIGITS         = 4,
   parameter int REFRESH_DIV      = 50000,
   parameter int DEAD_CYCLES      = 500,
   parameter int ANODE_ACTIVE_LOW = 1,
   localparam int IDX_W           = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*N_DIGITS-1:0]   value_in,
   input  logic                    load,
   input  logic                    blank_lz,
   output logic [3:0]              digit_bin,
   output logic [N_DIGITS-1:0]     anode,
   output logic [IDX_W-1:0]        digit_idx,
   output logic                    upd_pending
);

   localparam int                CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_DEAD = CNT_W'(DEAD_CYCLES);
   localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(N_DIGITS - 1);
   localparam bit                ACT_LOW  = (ANODE_ACTIVE_LOW != 0);
   localparam logic [N_DIGITS-1:0] ANODE_OFF = {N_DIGITS{ACT_LOW}};

   logic [CNT_W-1:0]      r_cnt;
   logic [IDX_W-1:0]      r_idx;
   logic [4*N_DIGITS-1:0] r_shown;
   logic [4*N_DIGITS-1:0] r_pending;
   logic                  r_upd;
   logic [3:0]            r_digit_bin;
   logic [N_DIGITS-1:0]   r_anode;

   logic                  w_cnt_wrap;
   logic                  w_idx_wrap;
   logic                  w_frame;
   logic                  w_commit;
   logic                  w_upd_next;
   logic [CNT_W-1:0]      w_cnt_next;
   logic [IDX_W-1:0]      w_idx_next;
   logic [4*N_DIGITS-1:0] w_shown_next;
   logic [3:0]            w_nib [N_DIGITS];
   logic [N_DIGITS-1:0]   w_zero;
   logic [N_DIGITS-1:1]   w_zero_above;
   logic [N_DIGITS-1:0]   w_blank;
   logic                  w_lit;
   logic [N_DIGITS-1:0]   w_anode_next;

   assign w_cnt_wrap = (r_cnt == CNT_MAX);
   assign w_idx_wrap = (r_idx == IDX_MAX);
   assign w_frame    = w_cnt_wrap & w_idx_wrap;
   assign w_cnt_next = w_cnt_wrap ? '0 : r_cnt + 1'b1;
   assign w_idx_next = !w_cnt_wrap ? r_idx : (w_idx_wrap ? '0 : r_idx + 1'b1);

   // A load landing on the boundary edge supersedes the old pending value, so it must not commit.
   assign w_commit     = w_frame & r_upd & ~load;
   assign w_shown_next = w_commit ? r_pending : r_shown;
   assign w_upd_next   = load ? 1'b1 : (w_frame ? 1'b0 : r_upd);

   genvar gi;
   generate
      for (gi = 0; gi < N_DIGITS; gi++) begin : g_nib
         assign w_nib[gi]  = w_shown_next[4*gi +: 4];
         assign w_zero[gi] = (w_nib[gi] == 4'h0);
      end

      // Running "this digit and everything above it is zero" chain, from the top digit down.
      for (gi = 1; gi < N_DIGITS; gi++) begin : g_zero_above
         if (gi == N_DIGITS - 1) begin : g_top
            assign w_zero_above[gi] = w_zero[gi];
         end else begin : g_mid
            assign w_zero_above[gi] = w_zero[gi] & w_zero_above[gi+1];
         end
      end

      for (gi = 0; gi < N_DIGITS; gi++) begin : g_blank
         if (gi == 0) begin : g_lsd
            assign w_blank[gi] = 1'b0;
         end else begin : g_upper
            assign w_blank[gi] = blank_lz & w_zero_above[gi];
         end
      end
   endgenerate

   assign w_lit = (w_cnt_next >= CNT_DEAD) & ~w_blank[w_idx_next];

   generate
      for (gi = 0; gi < N_DIGITS; gi++) begin : g_anode
         assign w_anode_next[gi] = ((w_idx_next == IDX_W'(gi)) & w_lit) ^ ACT_LOW;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_idx       <= '0;
         r_shown     <= '0;
         r_pending   <= '0;
         r_upd       <= 1'b0;
         r_digit_bin <= 4'h0;
         r_anode     <= ANODE_OFF;
      end else begin
         r_cnt       <= w_cnt_next;
         r_idx       <= w_idx_next;
         r_shown     <= w_shown_next;
         r_upd       <= w_upd_next;
         r_digit_bin <= w_nib[w_idx_next];
         r_anode     <= w_anode_next;
         if (load) begin
            r_pending <= value_in;
         end
      end
   end

   assign digit_bin   = r_digit_bin;
   assign anode       = r_anode;
   assign digit_idx   = r_idx;
   assign upd_pending = r_upd;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: directed scenarios with literal checks, then random loads/blanking
// compared every cycle against a time-based model; two instances cover both anode polarities.
module tb_seven_seg_scanner;

   localparam int N = 4;
   localparam int R = 4;
   localparam int D = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] value_in = 16'h0;
   logic        load = 1'b0;
   logic        blank_lz = 1'b0;

   logic [3:0]  bin_a, bin_b;
   logic [3:0]  anode_a, anode_b;
   logic [1:0]  idx_a, idx_b;
   logic        upd_a, upd_b;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: time in edges since reset release plus the value registers.
   int          m_t = 0;
   logic [15:0] m_shown = 16'h0;
   logic [15:0] m_pend = 16'h0;
   logic        m_upd = 1'b0;
   logic        m_blank = 1'b0;

   seven_seg_scanner #(.N_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D), .ANODE_ACTIVE_LOW(1)) dut_lo (
      .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load), .blank_lz(blank_lz),
      .digit_bin(bin_a), .anode(anode_a), .digit_idx(idx_a), .upd_pending(upd_a));

   seven_seg_scanner #(.N_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D), .ANODE_ACTIVE_LOW(0)) dut_hi (
      .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load), .blank_lz(blank_lz),
      .digit_bin(bin_b), .anode(anode_b), .digit_idx(idx_b), .upd_pending(upd_b));

   initial forever #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_t = 0; m_shown = 16'h0; m_pend = 16'h0; m_upd = 1'b0; m_blank = 1'b0;
         end else begin
            m_t = m_t + 1;
            if (load) begin
               m_pend = value_in;
               m_upd  = 1'b1;
            end else if ((m_t % (N*R)) == 0 && m_upd) begin
               m_shown = m_pend;
               m_upd   = 1'b0;
            end else if ((m_t % (N*R)) == 0) begin
               m_upd = 1'b0;
            end
            m_blank = blank_lz;
         end
      end
   end

   function automatic int exp_idx();
      return (m_t / R) % N;
   endfunction

   function automatic logic [3:0] exp_bin();
      logic [15:0] s;
      s = m_shown >> (4 * exp_idx());
      return s[3:0];
   endfunction

   function automatic logic [3:0] exp_anode(input bit act_low);
      int          idx;
      logic [15:0] above;
      bit          blank;
      logic [3:0]  oh;
      idx   = exp_idx();
      above = m_shown >> (4 * idx);
      blank = m_blank && (idx != 0) && (above == 16'h0);
      oh    = ((m_t % R) >= D && !blank) ? (4'b0001 << idx) : 4'b0000;
      return act_low ? ~oh : oh;
   endfunction

   always @(negedge clk) begin
      logic [3:0] ea, eb, eb_bin;
      logic [1:0] ei;
      ea = exp_anode(1'b1);
      eb = exp_anode(1'b0);
      eb_bin = exp_bin();
      ei = 2'(exp_idx());
      n_checks++;
      if (idx_a !== ei || bin_a !== eb_bin || anode_a !== ea || upd_a !== m_upd ||
          idx_b !== ei || bin_b !== eb_bin || anode_b !== eb || upd_b !== m_upd) begin
         n_errors++;
         $display("FAIL model t=%0d idx %0d/%0d req %0d bin %h/%h req %h anode_lo %b req %b anode_hi %b req %b upd %b/%b req %b",
                  m_t, idx_a, idx_b, ei, bin_a, bin_b, eb_bin, anode_a, ea, anode_b, eb, upd_a, upd_b, m_upd);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic at_t(input int target);
      int guard;
      guard = 0;
      while (m_t < target && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      n_checks++;
      if (m_t != target) begin
         n_errors++;
         $display("FAIL wait_t actual=%0d required=%0d", m_t, target);
      end
   endtask

   initial begin
      logic [15:0] v;
      int k;
      repeat (3) @(negedge clk);
      chk("reset_anode_lo", 32'(anode_a), 32'h0000000F);
      chk("reset_anode_hi", 32'(anode_b), 32'h00000000);
      chk("reset_bin", 32'(bin_a), 32'h0);
      chk("reset_upd", 32'(upd_a), 32'h0);
      rst_n = 1'b1;

      // Scan sequence with all digits lit
      at_t(1);   chk("scan_t1_lo", 32'(anode_a), 32'b1110); chk("scan_t1_hi", 32'(anode_b), 32'b0001);
      at_t(4);   chk("scan_t4_lo", 32'(anode_a), 32'b1111); chk("scan_t4_idx", 32'(idx_a), 32'd1);
                 chk("scan_t4_hi", 32'(anode_b), 32'b0000);
      at_t(5);   chk("scan_t5_lo", 32'(anode_a), 32'b1101);
      at_t(13);  chk("scan_t13_lo", 32'(anode_a), 32'b0111); chk("scan_t13_hi", 32'(anode_b), 32'b1000);
                 chk("scan_t13_idx", 32'(idx_a), 32'd3);
      at_t(16);  chk("scan_wrap_idx", 32'(idx_a), 32'd0); chk("scan_wrap_lo", 32'(anode_a), 32'b1111);

      // Mid-frame load becomes visible only at the next wrap
      at_t(20);  value_in = 16'h12AF; load = 1'b1;
      at_t(21);  load = 1'b0; chk("load_pending", 32'(upd_a), 32'd1);
      at_t(31);  chk("load_hold_bin", 32'(bin_a), 32'h0); chk("load_hold_upd", 32'(upd_a), 32'd1);
      at_t(32);  chk("load_apply_upd", 32'(upd_a), 32'd0); chk("load_bin0", 32'(bin_a), 32'hF);
      at_t(33);  chk("load_anode0", 32'(anode_a), 32'b1110);
      at_t(36);  chk("load_bin1", 32'(bin_a), 32'hA);
      at_t(40);  chk("load_bin2", 32'(bin_a), 32'h2);
      at_t(44);  chk("load_bin3", 32'(bin_a), 32'h1);

      // Leading-zero blanking
      at_t(48);  value_in = 16'h0030; load = 1'b1; blank_lz = 1'b1;
      at_t(49);  load = 1'b0;
      at_t(65);  chk("blank_d0", 32'(anode_a), 32'b1110);
      at_t(69);  chk("blank_d1", 32'(anode_a), 32'b1101); chk("blank_d1_bin", 32'(bin_a), 32'h3);
      at_t(73);  chk("blank_d2", 32'(anode_a), 32'b1111);
      at_t(77);  chk("blank_d3", 32'(anode_a), 32'b1111);
      at_t(80);  value_in = 16'h0000; load = 1'b1;
      at_t(81);  load = 1'b0;
      at_t(97);  chk("zero_d0", 32'(anode_a), 32'b1110); chk("zero_d0_bin", 32'(bin_a), 32'h0);
      at_t(101); chk("zero_d1", 32'(anode_a), 32'b1111);
      at_t(109); chk("zero_d3", 32'(anode_a), 32'b1111);
      at_t(112); blank_lz = 1'b0;
      at_t(117); chk("noblank_d1", 32'(anode_a), 32'b1101);
      at_t(125); chk("noblank_d3", 32'(anode_a), 32'b0111);

      // Load colliding with the wrap edge
      at_t(130); value_in = 16'h1111; load = 1'b1;
      at_t(131); load = 1'b0;
      at_t(143); value_in = 16'h2222; load = 1'b1;
      at_t(144); load = 1'b0; chk("coll_upd", 32'(upd_a), 32'd1); chk("coll_bin", 32'(bin_a), 32'h0);
      at_t(150); chk("coll_bin_mid", 32'(bin_a), 32'h0);
      at_t(160); chk("coll_apply_upd", 32'(upd_a), 32'd0); chk("coll_apply_bin", 32'(bin_a), 32'h2);
      at_t(164); chk("coll_apply_bin1", 32'(bin_a), 32'h2);

      // Asynchronous reset mid-slot (digit 2, cnt 2)
      at_t(170); chk("pre_rst_idx", 32'(idx_a), 32'd2); chk("pre_rst_lo", 32'(anode_a), 32'b1011);
      #2 rst_n = 1'b0;
      #1 chk("arst_lo", 32'(anode_a), 32'hF); chk("arst_hi", 32'(anode_b), 32'h0);
      chk("arst_bin", 32'(bin_a), 32'h0); chk("arst_idx", 32'(idx_a), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      at_t(1);   chk("post_rst_bin0", 32'(bin_a), 32'h0);
      at_t(5);   chk("post_rst_bin1", 32'(bin_a), 32'h0); chk("post_rst_lo", 32'(anode_a), 32'b1101);

      // Random loads and blanking against the model
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         load = ($urandom_range(0, 15) == 0);
         if (load) begin
            v = 16'($urandom);
            k = $urandom_range(0, 4);
            value_in = v & (16'hFFFF >> (4 * k));
         end
         if ($urandom_range(0, 63) == 0) blank_lz = 1'($urandom);
      end
      @(negedge clk);
      load = 1'b0;
      repeat (40) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Time-multiplexed scan controller for an N-digit common-anode/common-cathode 7-segment display. It sits directly upstream of the hex-nibble-to-segment decoder. It latches a packed hex value, cycles through the digits, and drives the current digit's 4-bit nibble to the decoder and the matching digit-enable line. Supports leading-zero blanking, anti-ghosting dead time and tear-free frame-synchronous updates.

Parameters:
N_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 50000, clk cycles per digit slot (>= DEAD_CYCLES+2)
DEAD_CYCLES, 500, cycles at the start of each slot with all anodes inactive
ANODE_ACTIVE_LOW, 1, 1 means an enabled digit drives 0; 0 means it drives 1

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
value_in  input  4*N_DIGITS  packed hex value; nibble k (bits 4k+3:4k) is digit k; digit 0 is least significant
load  input  1  single-cycle strobe that captures value_in into the pending register
blank_lz  input  1  1 blanks leading zero digits
digit_bin  output  4  nibble for the active digit, feeds the decoder bin input
anode  output  N_DIGITS  digit enables, one-hot when a digit is lit, else all inactive
digit_idx  output  $clog2(N_DIGITS)  index of the current slot
upd_pending  output  1  a loaded value is waiting for the frame boundary

Behaviour:
- Async reset (rst_n=0), effective immediately:
  - cnt=0, digit_idx=0, shown=0, pending=0, upd_pending=0.
  - digit_bin=0.
  - anode all inactive: all-1 if ANODE_ACTIVE_LOW, otherwise all-0.
- Release of reset is synchronous to clk. The first slot is digit 0 with cnt=0.
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1.
  - At cnt==REFRESH_DIV-1: cnt->0 and digit_idx advances, wrapping N_DIGITS-1 -> 0.
- Frame boundary: the edge where digit_idx wraps N_DIGITS-1 -> 0.
- Update handshake:
  - On load=1: pending<=value_in and upd_pending<=1.
  - At a frame boundary with upd_pending=1: shown<=pending and upd_pending<=0.
  - load on the same edge as a frame boundary: value_in is written to pending, and upd_pending stays 1. The previous pending value is discarded and does not reach shown. The new value is applied at the next frame boundary.
  - Repeated loads before a boundary: last one wins.
  - The displayed value never changes mid-frame.
- Blanking:
  - Digit k is blank when blank_lz=1 and shown nibbles N_DIGITS-1..k are all zero.
  - Digit 0 is never blank, so the value 0 shows a single "0".
  - blank_lz is sampled combinationally against shown each cycle.
- Outputs are registered and update on the edge where cnt/digit_idx take their new values, so they are aligned with digit_idx.
  - anode[digit_idx] is active iff cnt>=DEAD_CYCLES and digit_idx is not blank. All other bits are always inactive.
  - digit_bin = shown nibble[digit_idx] throughout the slot, including dead time. A blank digit still outputs its nibble (0).
- Latency:
  - load to visible takes at most N_DIGITS*REFRESH_DIV+1 cycles after the strobe.
  - Digit change to anode enable takes exactly DEAD_CYCLES cycles.
- Widths:
  - The cnt width is sized for REFRESH_DIV-1.
  - digit_idx is a minimum of 1 bit.
- No combinational path from any input to any output.

Test Plan:
1. Reset and scan (N=4, REFRESH_DIV=4, DEAD=1): hold rst_n=0 -> anode=4'b1111, digit_bin=0. Release -> digit_idx steps 0,1,2,3,0 every 4 clk. Anode is 1111 for 1 cycle each slot, then 1110/1101/1011/0111 for 3 cycles.
2. Load 16'h12AF at mid-frame -> upd_pending=1 until the next wrap to 0. Then digit_bin sequence is F,A,2,1 and upd_pending=0. Nothing changes before the wrap.
3. Blanking: shown=16'h0030, blank_lz=1 -> digits 3 and 2 are dark (anode stays 1111 in their slots), digits 1 and 0 are lit. Value 16'h0000 -> only digit 0 lit with nibble 0. blank_lz=0 -> all four lit.
4. Collision: load 16'h1111, then load 16'h2222 on the exact wrap edge -> shown stays at the old value for that frame. upd_pending stays 1, and 2222 appears after the following wrap. 1111 is never displayed.
5. Async reset mid-slot (digit_idx=2, cnt=2) -> outputs go to reset values within the same cycle without waiting for clk. shown=0 after release.
6. ANODE_ACTIVE_LOW=0 rerun of scenario 1 -> anode is 0000 in dead time, then 0001/0010/0100/1000.
